// File: rtl/id_stage.sv
`timescale 1ns/1ps
// RV32I OP-IMM decode/operand-fetch stage: one registered output bundle for the
// I-type ALU, with an internal register file, writeback bypass and stall refresh.
module id_stage #(
  parameter int         XLEN     = 32,
  parameter int         NREGS    = 32,
  parameter logic [6:0] I_OPCODE = 7'b0010011
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [11:0]     imm,
  output logic [XLEN-1:0] in1,
  output logic [4:0]      rd,
  output logic            illegal
);

  logic [XLEN-1:0] regs [NREGS];
  logic [4:0]      rs1;
  logic [4:0]      held_rs1;
  logic [XLEN-1:0] rs1_val;
  logic            accept;
  logic            consume;
  logic            refresh;
  logic            dec_illegal;

  assign rs1         = instr[19:15];
  assign instr_ready = !out_valid || out_ready;
  assign accept      = instr_valid && instr_ready;
  assign consume     = out_valid && out_ready;

  // A stalled bundle picks up a late writeback to its source register.
  assign refresh = out_valid && !out_ready && wb_en &&
                   (wb_rd == held_rs1) && (held_rs1 != 5'd0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rs1_val = regs[rs1];
    if (rs1 == 5'd0) begin
      rs1_val = '0;
    end else if (wb_en && (wb_rd == rs1)) begin
      rs1_val = wb_data;
    end
  end

  always_comb begin
    dec_illegal = 1'b0;
    if (instr[6:0] != I_OPCODE) begin
      dec_illegal = 1'b1;
    end else if ((instr[14:12] == 3'd1) && (instr[31:25] != 7'h00)) begin
      dec_illegal = 1'b1;
    end else if ((instr[14:12] == 3'd5) &&
                 (instr[31:25] != 7'h00) && (instr[31:25] != 7'h20)) begin
      dec_illegal = 1'b1;
    end
  end

  // NOTE: the register file is built from resettable flops because reset must
  // clear every entry; a RAM macro could not do that in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      opcode    <= '0;
      funct3    <= '0;
      imm       <= '0;
      in1       <= '0;
      rd        <= '0;
      illegal   <= 1'b0;
      held_rs1  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      opcode    <= instr[6:0];
      funct3    <= instr[14:12];
      imm       <= instr[31:20];
      in1       <= rs1_val;
      rd        <= instr[11:7];
      illegal   <= dec_illegal;
      held_rs1  <= rs1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end else if (refresh) begin
      in1 <= wb_data;
    end
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode/operand-fetch stage directly upstream of the I-type ALU.
- Accepts 32-bit RV32I instruction words over a valid/ready handshake and extracts opcode, funct3, imm[11:0] and rd.
- Reads rs1 from an internal 32x32 register file, which has a writeback port and bypass.
- Presents one registered bundle (opcode, funct3, imm, in1) that drives the ALU inputs directly.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, architectural register count; x0 hardwired to zero.
- I_OPCODE, 7'b0010011, opcode of the OP-IMM class handled downstream.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  upstream instruction valid.
- instr_ready  out  1  stage can accept an instruction this cycle.
- instr  in  32  instruction word.
- wb_en  in  1  register writeback enable.
- wb_rd  in  5  writeback destination register.
- wb_data  in  XLEN  writeback value.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream consumes the bundle.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- imm  out  12  instr[31:20], raw and not sign-extended.
- in1  out  XLEN  rs1 operand value.
- rd  out  5  instr[11:7].
- illegal  out  1  bundle is not a legal OP-IMM instruction.

Behaviour:
- Reset (synchronous, active-high):
  - out_valid, opcode, funct3, imm, in1, rd, illegal all go to 0.
  - All register-file entries are cleared to 0.
  - Any in-flight bundle is discarded.
  - instr_ready is 1 in the first cycle after reset deasserts.
- Handshake:
  - instr_ready = !out_valid || out_ready (combinational). Single output register; no skid buffer.
  - Accept occurs when instr_valid && instr_ready. The bundle is registered and out_valid = 1 in the next cycle (latency 1).
  - Consume occurs when out_valid && out_ready. out_valid drops next cycle unless a new accept happens in the same cycle (back-to-back, full throughput).
  - While out_valid && !out_ready, every output is held stable, with the in1 refresh below as the only exception.
- Field decode on accept:
  - rs1 = instr[19:15].
  - All other fields are copied verbatim.
- in1 selection on accept:
  - If rs1 == 0, in1 = 0.
  - Else if wb_en && wb_rd == rs1, in1 = wb_data (same-cycle bypass).
  - Else in1 = regfile[rs1].
- Stall refresh:
  - While out_valid && !out_ready, if wb_en, wb_rd == held rs1 and held rs1 != 0, then in1 updates to wb_data on the next edge.
  - The held rs1 is stored internally.
- Register file:
  - Write when wb_en && wb_rd != 0.
  - Writes to x0 are ignored; x0 always reads 0.
  - Writes proceed regardless of handshake state.
- illegal is computed from the accepted instr and is 1 if any of these holds:
  - opcode != I_OPCODE.
  - funct3 == 1 && imm[11:5] != 0.
  - funct3 == 5 && imm[11:5] is neither 7'h00 nor 7'h20.
  - Illegal bundles still flow through the handshake unchanged; the downstream stage decides what to do with them.
- Simultaneous consume, accept and writeback all resolve in one edge: the new bundle loads using the bypass rule.

Test Plan:
1. Reset, then instr=0x06400293 (addi x5,x0,100) with instr_valid=1 and out_ready=1. Required next cycle: out_valid=1, opcode=0x13, funct3=0, imm=0x064, rd=5, in1=0, illegal=0.
2. wb_en with x1=0x12345678; a later cycle accepts 0x7FF08113 (addi x2,x1,2047). Required: in1=0x12345678, imm=0x7FF, rd=2.
3. Same-cycle bypass: accept 0x7FF08113 in the same cycle as wb_en, wb_rd=1, wb_data=0xDEADBEEF. Required: in1=0xDEADBEEF.
4. Accept 0x02309193 (funct3=1, imm=0x023). Required: illegal=1.
5. Accept 0x00000000. Required: opcode=0, illegal=1.
6. Backpressure: hold out_ready=0 with a bundle valid. Required:
   - instr_ready=0 and all fields stable for 5 cycles.
   - wb x1=0xCAFEF00D during the stall gives in1=0xCAFEF00D next cycle.
   - Raising out_ready then allows back-to-back accepts every cycle.
   - A wb to x0 mid-stall leaves in1 unchanged.
   - Asserting reset mid-stall gives out_valid=0, instr_ready=1, and a later read of x1 returns 0.
